uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Host-side command initiator for the UART register/ALU command protocol. It accepts one command at a time over a valid/ready request port and serializes it into protocol frame bytes for a UART transmitter. It then collects the response bytes from a UART receiver and returns the assembled result, or a timeout indication. It sits at the far end of the serial link from the system's command decoder and response builder, and serves as a bench/host master or as a bridge for a second chip.

## Interface

Parameters:

- WIDTH, 8, data/byte width
- ADDR, 4, register address width
- TIMEOUT, 1023, maximum idle cycles allowed while waiting for a response byte

Ports:

- CLK  in  1  single clock
- RST  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block can accept a command
- CMD_TYPE  in  2  00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands
- CMD_ADDR  in  ADDR  register address (write/read)
- CMD_DATA  in  WIDTH  write data (type 00) or operand A (type 10)
- CMD_OPB  in  WIDTH  operand B (type 10)
- CMD_FUN  in  4  ALU function (types 10/11)
- TX_DATA  out  WIDTH  frame byte to UART transmitter
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  transmitter accepts byte (transfer = TX_VALID & TX_READY)
- RX_DATA  in  WIDTH  received response byte
- RX_VALID  in  1  one-cycle pulse, RX_DATA valid
- RSP_DATA  out  2*WIDTH  assembled response
- RSP_VALID  out  1  one-cycle pulse, command completed
- RSP_TIMEOUT  out  1  one-cycle pulse, response timed out
- BUSY  out  1  high whenever not IDLE

## Operation

- Frames, bytes sent in order, each byte held stable until transferred:
  - Type 00: 0xAA, {0,ADDR}, DATA. No response.
  - Type 01: 0xBB, {0,ADDR}. Response is 1 byte.
  - Type 10: 0xCC, A, B, {0,FUN}. Response is 2 bytes, LSB first.
  - Type 11: 0xDD, {0,FUN}. Response is 2 bytes, LSB first.
- Address and FUN are zero-extended to WIDTH.
- States:
  - IDLE: CMD_READY=1. On CMD_VALID, latch all CMD_* fields into the command register and go to SEND. Clear byte index, response count and RSP_DATA.
  - SEND: TX_VALID=1, TX_DATA=frame[index]. On each transfer, index+1. On transfer of the last byte:
    - type 00 → DONE
    - all other types → WAIT_RSP, with the timeout counter cleared
  - WAIT_RSP:
    - Each RX_VALID stores RX_DATA into RSP_DATA byte[rcount], rcount+1, and clears the timeout counter.
    - When rcount reaches the expected count (1 or 2) → DONE.
    - Otherwise the counter increments each cycle. When it equals TIMEOUT → IDLE, pulse RSP_TIMEOUT; RSP_DATA retains any partial bytes.
  - DONE: pulse RSP_VALID for one cycle → IDLE.
- Read result is {8'h00, byte0}. Write result is 16'h0000.
- RX_VALID outside WAIT_RSP is ignored; it does not change RSP_DATA or the counters.
- CMD_* inputs are not observed after the accept cycle.
- Timeout counter width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing

- Reset values (asynchronous, RST=0):
  - state IDLE, so CMD_READY=1 and BUSY=0
  - TX_VALID=0, TX_DATA=0
  - RSP_DATA=0, RSP_VALID=0, RSP_TIMEOUT=0
  - all counters 0
- Reset mid-frame aborts immediately. No partial byte, RSP_VALID or RSP_TIMEOUT is emitted after release.
- CMD_READY and BUSY are decoded combinationally from state; all other outputs are registered.
- Command accepted in cycle N → TX_VALID=1 with the first byte in N+1.
- Back-to-back transfers: with TX_READY held high, one byte transfers per cycle, with no bubble between bytes.
- Final response byte on RX_VALID in cycle M:
  - RSP_DATA updated and state=DONE in M+1
  - RSP_VALID=1 in M+1
  - IDLE (CMD_READY=1) in M+2
- Write: last byte transferred in cycle M → RSP_VALID in M+1.
- Timeout: RSP_TIMEOUT is high for exactly one cycle, on the IDLE-entry cycle.
- RX_VALID in the same cycle the counter reaches TIMEOUT: the byte is taken and the timeout is cancelled.
- RSP_VALID and RSP_TIMEOUT are never high together.
- TX_READY low stalls SEND indefinitely; SEND has no timeout.

## Test plan

- **Write:** CMD_TYPE=00, ADDR=3, DATA=0x5A, TX_READY=1.
  - TX bytes AA,03,5A in 3 consecutive cycles.
  - RSP_VALID with RSP_DATA=0x0000 one cycle after the last byte.
  - CMD_READY one cycle later.
- **Read with TX stalls:** CMD_TYPE=01, ADDR=2; TX_READY toggles 1,0,0,1; RX returns 0x3C.
  - TX bytes BB,02, each held through the stall.
  - RSP_VALID=1 with RSP_DATA=0x003C in the cycle after RX_VALID.
- **ALU with operands:** CMD_TYPE=10, A=0x12, B=0x34, FUN=0; RX returns 0x46 then 0x00.
  - TX bytes CC,12,34,00.
  - RSP_DATA=0x0046 with one RSP_VALID pulse.
- **Timeout:** CMD_TYPE=11, FUN=1, TIMEOUT=20; one RX byte 0x07, then silence.
  - RSP_TIMEOUT pulses 20 cycles after that byte.
  - RSP_DATA=0x0007, no RSP_VALID, return to IDLE.
- **Stray RX and reset:**
  - RX_VALID pulses while in IDLE or SEND leave RSP_DATA=0.
  - RST asserted during the second TX byte: all outputs reset at once, CMD_READY=1.
  - A new write after release produces a correct frame.

Source files
------------

// File: rtl/uart_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_master
// Brief    : Host-side command initiator; frames one command into UART TX bytes
//            and collects the 1- or 2-byte response, or reports a timeout.
// Revision : 1.0
// ============================================================================
module uart_cmd_master #(
    parameter int WIDTH   = 8,
    parameter int ADDR    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_type_i,
    input  logic [ADDR-1:0]    cmd_addr_i,
    input  logic [WIDTH-1:0]   cmd_data_i,
    input  logic [WIDTH-1:0]   cmd_opb_i,
    input  logic [3:0]         cmd_fun_i,
    output logic [WIDTH-1:0]   tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    input  logic [WIDTH-1:0]   rx_data_i,
    input  logic               rx_valid_i,
    output logic [2*WIDTH-1:0] rsp_data_o,
    output logic               rsp_valid_o,
    output logic               rsp_timeout_o,
    output logic               busy_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] HDR_WR   = 8'hAA;
    localparam logic [7:0] HDR_RD   = 8'hBB;
    localparam logic [7:0] HDR_ALU2 = 8'hCC;
    localparam logic [7:0] HDR_ALU0 = 8'hDD;

    localparam logic [1:0] T_WRITE = 2'b00;
    localparam logic [1:0] T_READ  = 2'b01;
    localparam logic [1:0] T_ALU2  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [ADDR-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]         fun_q, fun_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         rcount_q, rcount_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [WIDTH-1:0]   tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic               tx_fire;
    logic [1:0]         idx_inc;
    logic [1:0]         rcount_inc;
    logic [TW-1:0]      tmo_inc;

    // Frame byte at position idx for a command; address and FUN zero-extended.
    function automatic logic [WIDTH-1:0] frame_byte(
        input logic [1:0]       typ,
        input logic [ADDR-1:0]  addr,
        input logic [WIDTH-1:0] opa,
        input logic [WIDTH-1:0] opb,
        input logic [3:0]       fun,
        input logic [1:0]       idx
    );
        logic [WIDTH-1:0] b;
        b = '0;
        case (typ)
            2'b00: begin
                case (idx)
                    2'd0:    b = WIDTH'(HDR_WR);
                    2'd1:    b = WIDTH'(addr);
                    default: b = opa;
                endcase
            end
            2'b01: begin
                if (idx == 2'd0) b = WIDTH'(HDR_RD);
                else             b = WIDTH'(addr);
            end
            2'b10: begin
                case (idx)
                    2'd0:    b = WIDTH'(HDR_ALU2);
                    2'd1:    b = opa;
                    2'd2:    b = opb;
                    default: b = WIDTH'(fun);
                endcase
            end
            default: begin
                if (idx == 2'd0) b = WIDTH'(HDR_ALU0);
                else             b = WIDTH'(fun);
            end
        endcase
        return b;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] typ);
        case (typ)
            2'b00:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [1:0] rsp_len(input logic [1:0] typ);
        return (typ == T_READ) ? 2'd1 : 2'd2;
    endfunction

    assign tx_fire    = tx_valid_q & tx_ready_i;
    assign idx_inc    = idx_q + 2'd1;
    assign rcount_inc = rcount_q + 2'd1;
    assign tmo_inc    = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        data_d        = data_q;
        opb_d         = opb_q;
        fun_d         = fun_q;
        idx_d         = idx_q;
        rcount_d      = rcount_q;
        tmo_d         = tmo_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    type_d     = cmd_type_i;
                    addr_d     = cmd_addr_i;
                    data_d     = cmd_data_i;
                    opb_d      = cmd_opb_i;
                    fun_d      = cmd_fun_i;
                    idx_d      = 2'd0;
                    rcount_d   = 2'd0;
                    tmo_d      = '0;
                    rsp_data_d = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_byte(cmd_type_i, cmd_addr_i, cmd_data_i,
                                            cmd_opb_i, cmd_fun_i, 2'd0);
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_fire) begin
                    if (idx_q == last_idx(type_q)) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = '0;
                        if (type_q == T_WRITE) begin
                            state_d     = S_DONE;
                            rsp_valid_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_RSP;
                            tmo_d   = '0;
                        end
                    end else begin
                        idx_d     = idx_inc;
                        tx_data_d = frame_byte(type_q, addr_q, data_q, opb_q,
                                               fun_q, idx_inc);
                    end
                end
            end

            S_WAIT_RSP: begin
                // A byte arriving on the would-be timeout cycle wins.
                if (rx_valid_i) begin
                    if (rcount_q[0]) rsp_data_d[2*WIDTH-1:WIDTH] = rx_data_i;
                    else             rsp_data_d[WIDTH-1:0]       = rx_data_i;
                    rcount_d = rcount_inc;
                    tmo_d    = '0;
                    if (rcount_inc == rsp_len(type_q)) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TW'(TIMEOUT)) begin
                        state_d       = S_IDLE;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            type_q        <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            opb_q         <= '0;
            fun_q         <= '0;
            idx_q         <= '0;
            rcount_q      <= '0;
            tmo_q         <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            opb_q         <= opb_d;
            fun_q         <= fun_d;
            idx_q         <= idx_d;
            rcount_q      <= rcount_d;
            tmo_q         <= tmo_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_master
// Brief    : Directed self-checking bench for uart_cmd_master (TIMEOUT = 20).
// Revision : 1.0
// ============================================================================
module tb_uart_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_opb;
    logic [3:0]  cmd_fun;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_cmd_master #(
        .WIDTH   (8),
        .ADDR    (4),
        .TIMEOUT (20)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_type_i    (cmd_type),
        .cmd_addr_i    (cmd_addr),
        .cmd_data_i    (cmd_data),
        .cmd_opb_i     (cmd_opb),
        .cmd_fun_i     (cmd_fun),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rsp_data_o    (rsp_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_timeout_o (rsp_timeout),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tx(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_data"},  32'(tx_data),  32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_addr = 4'd0;
        cmd_data = 8'd0; cmd_opb = 8'd0; cmd_fun = 4'd0; tx_ready = 1'b0;
        rx_data = 8'd0; rx_valid = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_tx_valid",    32'(tx_valid),    32'd0);
        chk("rst_tx_data",     32'(tx_data),     32'd0);
        chk("rst_rsp_data",    32'(rsp_data),    32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write: AA 03 5A back to back, RSP_VALID next cycle, ready after that
        cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 4'd3; cmd_data = 8'h5A;
        tx_ready = 1'b1;
        chk("wr_accept_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0; cmd_addr = 4'hF; cmd_data = 8'hFF;
        chk_tx("wr_b0", 8'hAA);
        chk("wr_busy",      32'(busy),      32'd1);
        chk("wr_not_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk_tx("wr_b1", 8'h03);
        tick();
        chk_tx("wr_b2", 8'h5A);
        tick();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_data",  32'(rsp_data),  32'h0000);
        chk("wr_tx_idle",   32'(tx_valid),  32'd0);
        chk("wr_done_busy", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_back_ready", 32'(cmd_ready), 32'd1);
        chk("wr_rsp_pulse",  32'(rsp_valid), 32'd0);

        // Stray RX while idle
        rx_valid = 1'b1; rx_data = 8'h99;
        tick();
        rx_valid = 1'b0;
        chk("stray_idle_rsp", 32'(rsp_data), 32'h0000);

        // Read with TX stalls on both bytes; stray RX during SEND
        cmd_valid = 1'b1; cmd_type = 2'b01; cmd_addr = 4'd2; tx_ready = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_addr = 4'd0;
        chk_tx("rd_b0_stall", 8'hBB);
        tick();
        chk_tx("rd_b0_held", 8'hBB);
        tx_ready = 1'b1;
        tick();
        chk_tx("rd_b1", 8'h02);
        tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        rx_valid = 1'b0;
        chk_tx("rd_b1_held", 8'h02);
        tick();
        chk_tx("rd_b1_held2", 8'h02);
        tx_ready = 1'b1;
        tick();
        chk("rd_wait_tx_idle", 32'(tx_valid), 32'd0);
        chk("rd_wait_busy",    32'(busy),     32'd1);
        chk("stray_send_rsp",  32'(rsp_data), 32'h0000);
        rx_valid = 1'b1; rx_data = 8'h3C;
        tick();
        rx_valid = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_data",  32'(rsp_data),  32'h003C);
        tick();
        chk("rd_back_ready", 32'(cmd_ready), 32'd1);
        chk("rd_rsp_pulse",  32'(rsp_valid), 32'd0);

        // ALU with operands: CC 12 34 00, response 46 then 00
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_data = 8'h12; cmd_opb = 8'h34;
        cmd_fun = 4'd0;
        tick();
        cmd_valid = 1'b0; cmd_data = 8'h00; cmd_opb = 8'h00; cmd_fun = 4'hF;
        chk_tx("alu_b0", 8'hCC);
        tick();
        chk_tx("alu_b1", 8'h12);
        tick();
        chk_tx("alu_b2", 8'h34);
        tick();
        chk_tx("alu_b3", 8'h00);
        tick();
        chk("alu_wait_tx_idle", 32'(tx_valid), 32'd0);
        rx_valid = 1'b1; rx_data = 8'h46;
        tick();
        rx_valid = 1'b0;
        chk("alu_partial_data",  32'(rsp_data),  32'h0046);
        chk("alu_partial_valid", 32'(rsp_valid), 32'd0);
        tick();
        rx_valid = 1'b1; rx_data = 8'h00;
        tick();
        rx_valid = 1'b0;
        chk("alu_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("alu_rsp_data",  32'(rsp_data),  32'h0046);
        tick();
        chk("alu_rsp_pulse",  32'(rsp_valid), 32'd0);
        chk("alu_back_ready", 32'(cmd_ready), 32'd1);

        // Timeout: one byte 07, then silence; pulse 20 cycles after it is stored
        cmd_valid = 1'b1; cmd_type = 2'b11; cmd_fun = 4'd1;
        tick();
        cmd_valid = 1'b0; cmd_fun = 4'd0;
        chk_tx("to_b0", 8'hDD);
        tick();
        chk_tx("to_b1", 8'h01);
        tick();
        chk("to_wait_busy", 32'(busy), 32'd1);
        rx_valid = 1'b1; rx_data = 8'h07;
        tick();
        rx_valid = 1'b0;
        chk("to_partial", 32'(rsp_data), 32'h0007);
        for (int k = 0; k < 19; k++) begin
            chk("to_early_timeout", 32'(rsp_timeout), 32'd0);
            chk("to_no_valid",      32'(rsp_valid),   32'd0);
            tick();
        end
        chk("to_last_wait_busy", 32'(busy),        32'd1);
        chk("to_last_wait_to",   32'(rsp_timeout), 32'd0);
        tick();
        chk("to_pulse",      32'(rsp_timeout), 32'd1);
        chk("to_idle_ready", 32'(cmd_ready),   32'd1);
        chk("to_no_rsp",     32'(rsp_valid),   32'd0);
        chk("to_rsp_data",   32'(rsp_data),    32'h0007);
        tick();
        chk("to_pulse_end", 32'(rsp_timeout), 32'd0);

        // RX on the cycle the counter reaches TIMEOUT cancels the timeout
        cmd_valid = 1'b1; cmd_type = 2'b11; cmd_fun = 4'd2;
        tick();
        cmd_valid = 1'b0;
        chk_tx("edge_b0", 8'hDD);
        tick();
        chk_tx("edge_b1", 8'h02);
        tick();
        for (int k = 0; k < 19; k++) tick();
        rx_valid = 1'b1; rx_data = 8'hAB;
        tick();
        rx_valid = 1'b0;
        chk("edge_no_timeout", 32'(rsp_timeout), 32'd0);
        chk("edge_still_busy", 32'(busy),        32'd1);
        chk("edge_partial",    32'(rsp_data),    32'h00AB);
        tick();
        rx_valid = 1'b1; rx_data = 8'hCD;
        tick();
        rx_valid = 1'b0;
        chk("edge_rsp_valid", 32'(rsp_valid),   32'd1);
        chk("edge_rsp_data",  32'(rsp_data),    32'hCDAB);
        chk("edge_exclusive", 32'(rsp_timeout), 32'd0);
        tick();

        // Reset asserted while the second write byte is on the line
        cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 4'd7; cmd_data = 8'h11;
        tx_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk_tx("rst_wr_b0", 8'hAA);
        tick();
        chk_tx("rst_wr_b1", 8'h07);
        rst_n = 1'b0;
        #1;
        chk("arst_tx_valid",    32'(tx_valid),    32'd0);
        chk("arst_tx_data",     32'(tx_data),     32'd0);
        chk("arst_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("arst_busy",        32'(busy),        32'd0);
        chk("arst_rsp_data",    32'(rsp_data),    32'd0);
        chk("arst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_tx_valid",  32'(tx_valid),  32'd0);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_ready",     32'(cmd_ready), 32'd1);

        // Fresh write after reset release
        cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 4'd5; cmd_data = 8'hC3;
        tick();
        cmd_valid = 1'b0;
        chk_tx("wr2_b0", 8'hAA);
        tick();
        chk_tx("wr2_b1", 8'h05);
        tick();
        chk_tx("wr2_b2", 8'hC3);
        tick();
        chk("wr2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr2_rsp_data",  32'(rsp_data),  32'h0000);
        tick();
        chk("wr2_back_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
